cpu_mem_responder: RTL

Memory-side responder for the pipelined MIPS CPU. It serves the CPU's instruction port (`i_addr` → `i_datain`) and data port (`d_addr`, `d_dataout` → `d_datain`), replacing bench-driven stimulus with real storage. Instruction memory is a word array filled through a program-load port. Data memory is a single-ported word RAM fronted by a store buffer with load forwarding and a stall output when the buffer is full.

---
 rtl/cpu_mem_responder.sv | 98 +++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction memory with a program-load port, and a data RAM behind a
// store buffer that forwards to loads and stalls the CPU while it is full.
module cpu_mem_responder #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int SB_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] i_addr,
    output logic [31:0] i_datain,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dataout,
    input  logic        d_memread,
    input  logic        d_memwrite,
    output logic [31:0] d_datain,
    output logic        mem_stall,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        sb_empty,
    output logic        d_fault
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   imem [IMEM_WORDS];
    logic [31:0]   dmem [DMEM_WORDS];
    logic [DW-1:0] sb_idx [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [29:0]   i_idx, d_idx, p_idx;
    logic          full, d_bad, d_req, st_acc, ld_acc, drain, fwd_hit, unused_bits;
    logic [31:0]   fwd_data, ld_data;

    assign i_idx       = i_addr[31:2];
    assign d_idx       = d_addr[31:2];
    assign p_idx       = prog_addr[31:2];
    assign unused_bits = ^{i_addr[1:0], prog_addr[1:0]};

    assign full      = count == CW'(SB_DEPTH);
    assign d_bad     = d_addr[1:0] != 2'b00 || d_idx >= 30'(DMEM_WORDS);
    assign d_req     = d_memread | d_memwrite;
    assign mem_stall = d_req & full;
    assign sb_empty  = count == '0;
    assign st_acc    = d_memwrite & ~d_bad & ~full;
    assign ld_acc    = d_memread & ~full;
    // The RAM port belongs to an accepted load; when full no load is accepted, so drain is forced.
    assign drain     = count != '0 && !ld_acc;

    // Walk oldest to youngest from rd_ptr so the last hit is the youngest, independent of wrap.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (CW'(k) < count && sb_idx[rd_ptr + PW'(k)] == d_idx[DW-1:0]) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[rd_ptr + PW'(k)];
            end
        end
    end

    assign ld_data = (d_bad | d_memwrite) ? '0 : fwd_hit ? fwd_data : dmem[d_idx[DW-1:0]];

    always_ff @(posedge clock) begin
        if (prog_we && p_idx < 30'(IMEM_WORDS))
            imem[p_idx[IW-1:0]] <= prog_data;
        if (st_acc) begin
            sb_idx[wr_ptr]  <= d_idx[DW-1:0];
            sb_data[wr_ptr] <= d_dataout;
        end
        if (drain)
            dmem[sb_idx[rd_ptr]] <= sb_data[rd_ptr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_datain <= '0;
            d_datain <= '0;
            d_fault  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            i_datain <= prog_we ? '0 : i_idx < 30'(IMEM_WORDS) ? imem[i_idx[IW-1:0]] : '0;
            if (ld_acc)
                d_datain <= ld_data;
            if (d_req && !full && (d_bad || (d_memread && d_memwrite)))
                d_fault <= 1'b1;
            wr_ptr <= wr_ptr + PW'(st_acc);
            rd_ptr <= rd_ptr + PW'(drain);
            count  <= count + CW'(st_acc) - CW'(drain);
        end
    end
endmodule
